// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the round-robin UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_e;

  localparam int DATA_BITS = 8;

  // Widest requester vector the arbiter helper handles; narrower
  // configurations pad their request vector with zeros.
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set request at or above ptr, wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [2:0]         ptr,
                                    input int                 n);
    pick_t r;
    int    k;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = (int'(ptr) + i) % n;
      if (i < n && !r.found && req[k[2:0]]) begin
        r.found = 1'b1;
        r.idx   = k[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Per-bit baud counter: counts 0..max(div,1)-1 while enabled and flags
// the last clock of each bit period.
module uart_baud_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last;

  // A divisor of zero behaves like one so every bit lasts at least a clock.
  assign last   = (div_i == '0) ? '0 : div_i - DIV_W'(1);
  assign tick_o = en_i && (cnt_q == last);

  // Restart at zero on terminal count and whenever the line is idle.
  always_comb begin
    cnt_d = '0;
    if (en_i && !tick_o) cnt_d = cnt_q + DIV_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmit line between NUM_REQ
// byte sources; frames are start, 8 data bits LSB first, optional parity,
// one or two stop bits.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIV_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DIV_W-1:0]           cfg_baud_div,
  input  logic                       cfg_parity_en,
  input  logic                       cfg_parity_odd,
  input  logic                       cfg_two_stop,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);

  localparam int IDW = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d, gid_q, gid_d, gsel;
  logic [2:0]           bit_q, bit_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, gbyte;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 two_stop_q, two_stop_d;
  logic                 par_bit_q, par_bit_d;
  logic [MAX_REQ-1:0]   req8;
  pick_t                pick;
  logic                 tick;

  // Round-robin choice among the currently valid requesters.
  always_comb begin
    req8                = '0;
    req8[NUM_REQ-1:0]   = req_valid;
    pick                = rr_pick(req8, 3'(ptr_q), NUM_REQ);
  end

  assign gsel  = IDW'(pick.idx);
  assign gbyte = req_data[int'(gsel)*8 +: 8];

  uart_baud_counter #(.DIV_W(DIV_W)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q != IDLE),
    .div_i  (div_q),
    .tick_o (tick)
  );

  // Frame sequencer; tx_d is the line level for the bit being entered so
  // the pin comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    par_bit_d  = par_bit_q;
    req_ready  = '0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pick.found) begin
          req_ready[gsel] = 1'b1;
          shift_d    = gbyte;
          div_d      = cfg_baud_div;
          par_en_d   = cfg_parity_en;
          two_stop_d = cfg_two_stop;
          par_bit_d  = (^gbyte) ^ cfg_parity_odd;
          gid_d      = gsel;
          ptr_d      = (int'(gsel) == NUM_REQ - 1) ? '0 : gsel + IDW'(1);
          bit_d      = '0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: if (tick) begin
        tx_d    = shift_q[0];
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        if (bit_q == 3'(DATA_BITS - 1)) begin
          tx_d    = par_en_q ? par_bit_q : 1'b1;
          state_d = par_en_q ? PARITY : STOP1;
        end else begin
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
      PARITY: if (tick) begin
        tx_d    = 1'b1;
        state_d = STOP1;
      end
      STOP1: if (tick) begin
        tx_d = 1'b1;
        if (two_stop_q) state_d = STOP2;
        else begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      STOP2: if (tick) begin
        tx_d       = 1'b1;
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Control state; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Frame payload and configuration snapshot taken at grant.
  always_ff @(posedge clk) begin
    shift_q    <= shift_d;
    div_q      <= div_d;
    par_en_q   <= par_en_d;
    two_stop_q <= two_stop_d;
    par_bit_q  <= par_bit_d;
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a cycle-level reference model
// predicts grants and frame waveforms; a monitor compares them to the DUT.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DIV_W   = 16;
  localparam int IDW     = $clog2(NUM_REQ);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DIV_W-1:0]     cfg_baud_div;
  logic                 cfg_parity_en, cfg_parity_odd, cfg_two_stop;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx, busy, frame_done;
  logic [IDW-1:0]       grant_id;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DIV_W(DIV_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_baud_div   (cfg_baud_div),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_two_stop   (cfg_two_stop),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .tx             (tx),
    .busy           (busy),
    .grant_id       (grant_id),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] data;
    int         div;
    bit         pen;
    bit         podd;
    bit         two;
  } exp_t;

  exp_t       exp_q[$];
  int         dut_grants[$];
  logic [7:0] srcq[NUM_REQ][$];
  logic [NUM_REQ-1:0] drop = '0;
  int  n_chk = 0, n_pass = 0;
  int  cyc = 0, free_at = 0, mptr = 0;
  int  c_div = 4;
  bit  c_pen = 0, c_podd = 0, c_two = 0;
  bit  mon_en = 0, in_frame = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endfunction

  // Expected line level for every clock of a frame, built from the frame rules.
  function automatic int frame_bits(input exp_t e, output logic [127:0] w);
    logic [15:0] fb;
    int nb, d, idx;
    fb = '0; nb = 0;
    fb[nb] = 1'b0; nb++;
    for (int b = 0; b < 8; b++) begin fb[nb] = e.data[b]; nb++; end
    if (e.pen) begin fb[nb] = (^e.data) ^ e.podd; nb++; end
    fb[nb] = 1'b1; nb++;
    if (e.two) begin fb[nb] = 1'b1; nb++; end
    d = (e.div == 0) ? 1 : e.div;
    w = '1; idx = 0;
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < d; r++) begin w[idx] = fb[b]; idx++; end
    return nb * d;
  endfunction

  // Drive one cycle of stimulus and run the reference model on it.
  task automatic step();
    logic [NUM_REQ-1:0]   v;
    logic [NUM_REQ*8-1:0] d;
    exp_t e;
    logic [127:0] w;
    int g, j, len;
    @(posedge clk); #2;
    cyc++;
    v = '0; d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (srcq[i].size() > 0) begin
        d[8*i +: 8] = srcq[i][0];
        v[i] = !drop[i];
      end else d[8*i +: 8] = 8'($urandom);
    end
    req_valid      = v;
    req_data       = d;
    cfg_baud_div   = DIV_W'(c_div);
    cfg_parity_en  = c_pen;
    cfg_parity_odd = c_podd;
    cfg_two_stop   = c_two;
    if (reset && cyc >= free_at && v != '0) begin
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (mptr + k) % NUM_REQ;
        if (g < 0 && v[j]) g = j;
      end
      e.cyc = cyc; e.id = g; e.data = srcq[g][0]; e.div = c_div;
      e.pen = c_pen; e.podd = c_podd; e.two = c_two;
      exp_q.push_back(e);
      void'(srcq[g].pop_front());
      mptr = (g + 1) % NUM_REQ;
      len = frame_bits(e, w);
      free_at = cyc + 1 + len;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (srcq[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (!(all_empty() && cyc >= free_at && exp_q.size() == 0 && !in_frame) && n < max_cyc) begin
      step(); n++;
    end
    chk(n < max_cyc, "wait_idle_timeout", 128'(n), 128'(max_cyc));
    step();
  endtask

  // Monitor: pops expected frames on their grant cycle and checks the line.
  initial begin : monitor
    exp_t cur;
    logic [127:0] wexp, wact;
    logic [NUM_REQ-1:0] oh;
    int flen, pos, bcnt, dcnt, dpos;
    bit rdy_bad;
    forever begin
      @(negedge clk);
      if (!mon_en) begin in_frame = 0; continue; end
      if (req_ready != '0)
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) dut_grants.push_back(i);
      if (!in_frame) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          cur = exp_q.pop_front();
          flen = frame_bits(cur, wexp);
          oh = '0; oh[cur.id] = 1'b1;
          chk(req_ready == oh, "grant_ready", 128'(req_ready), 128'(oh));
          chk(tx && !busy, "grant_cycle_idle", 128'({tx, busy}), 128'(2'b10));
          in_frame = 1; pos = 0; wact = '1; bcnt = 0; dcnt = 0; dpos = -1; rdy_bad = 0;
        end else begin
          chk(req_ready == '0 && tx && !busy && !frame_done, "idle_line",
              128'({req_ready, tx, busy, frame_done}), 128'(3'b100));
        end
      end else begin
        if (pos == 0) chk(grant_id == IDW'(cur.id), "grant_id", 128'(grant_id), 128'(cur.id));
        wact[pos] = tx;
        if (busy) bcnt++;
        if (frame_done) begin dcnt++; dpos = pos; end
        if (req_ready != '0) rdy_bad = 1;
        pos++;
        if (pos == flen) begin
          chk(wact == wexp, "tx_frame", wact, wexp);
          chk(bcnt == flen, "busy_len", 128'(bcnt), 128'(flen));
          chk(dcnt == 1 && dpos == flen - 1, "frame_done_pos", 128'(dpos), 128'(flen - 1));
          chk(!rdy_bad, "ready_in_frame", 128'(rdy_bad), 128'(0));
          in_frame = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int gcyc;
    reset = 1'b0; req_valid = '0; req_data = '0;
    cfg_baud_div = DIV_W'(4); cfg_parity_en = 0; cfg_parity_odd = 0; cfg_two_stop = 0;
    repeat (3) @(posedge clk);
    #3;
    chk(tx == 1'b1 && busy == 1'b0, "reset_line", 128'({tx, busy}), 128'(2'b10));
    chk(req_ready == '0 && frame_done == 1'b0, "reset_handshake", 128'({req_ready, frame_done}), 128'(0));
    chk(grant_id == '0, "reset_grant_id", 128'(grant_id), 128'(0));
    reset = 1'b1; mon_en = 1;

    // Round-robin with all four requesters valid.
    c_div = 2; c_pen = 0; c_two = 0;
    srcq[0].push_back(8'h10); srcq[0].push_back(8'h10);
    srcq[1].push_back(8'h11); srcq[2].push_back(8'h12); srcq[3].push_back(8'h13);
    dut_grants.delete();
    wait_idle(400);
    chk(dut_grants.size() == 5, "rr_count", 128'(dut_grants.size()), 128'(5));
    if (dut_grants.size() == 5)
      for (int i = 0; i < 5; i++)
        chk(dut_grants[i] == (i % 4), "rr_order", 128'(dut_grants[i]), 128'(i % 4));

    // Single 0xA5 frame, div 4, no parity, one stop.
    c_div = 4;
    srcq[0].push_back(8'hA5);
    wait_idle(200);

    // Parity and two stop bits, both polarities.
    c_div = 2; c_pen = 1; c_two = 1; c_podd = 0;
    srcq[1].push_back(8'h07); wait_idle(200);
    c_podd = 1;
    srcq[1].push_back(8'h07); wait_idle(200);

    // Zero divisor means one clock per bit.
    c_div = 0; c_pen = 0; c_two = 0;
    srcq[2].push_back(8'h3C); wait_idle(200);

    // Divisor change mid-frame applies only to the next frame.
    c_div = 4;
    srcq[3].push_back(8'h81); srcq[3].push_back(8'h7E);
    while (cyc >= free_at) step();
    repeat (5) step();
    c_div = 8;
    wait_idle(400);

    // Requester 1 raises and drops valid while requester 0 is sending.
    c_div = 4;
    srcq[0].push_back(8'h55);
    while (cyc >= free_at) step();
    dut_grants.delete();
    repeat (3) step();
    srcq[1].push_back(8'hEE);
    repeat (10) step();
    srcq[1].delete();
    wait_idle(200);
    chk(dut_grants.size() == 1 && dut_grants[0] == 0, "withdrawn_not_granted",
        128'(dut_grants.size()), 128'(1));

    // Reset during DATA bit 3.
    c_div = 4;
    srcq[1].push_back(8'hC3);
    while (cyc >= free_at) step();
    gcyc = cyc;
    while (cyc < gcyc + 18) step();
    #1;
    mon_en = 0;
    reset = 1'b0;
    #1;
    chk(tx == 1'b1 && busy == 1'b0, "midframe_reset_line", 128'({tx, busy}), 128'(2'b10));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(frame_done == 1'b0 && tx == 1'b1, "reset_no_done", 128'({frame_done, tx}), 128'(1));
    end
    exp_q.delete(); mptr = 0; free_at = 0;
    @(posedge clk); #3;
    reset = 1'b1; mon_en = 1;
    dut_grants.delete();
    srcq[2].push_back(8'h5A);
    wait_idle(200);
    chk(dut_grants.size() == 1 && dut_grants[0] == 2, "post_reset_grant",
        128'(dut_grants.size() > 0 ? dut_grants[0] : -1), 128'(2));
    chk(grant_id == IDW'(2), "post_reset_grant_id", 128'(grant_id), 128'(2));

    // Randomized traffic with config churn and occasional valid drops.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        int r;
        r = $urandom_range(0, NUM_REQ - 1);
        if (srcq[r].size() < 3) srcq[r].push_back(8'($urandom));
      end
      for (int i = 0; i < NUM_REQ; i++) drop[i] = ($urandom_range(0, 7) == 0);
      c_div = $urandom_range(0, 5);
      c_pen = 1'($urandom); c_podd = 1'($urandom); c_two = 1'($urandom);
      step();
    end
    drop = '0;
    wait_idle(2000);
    chk(exp_q.size() == 0, "scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmit line between NUM_REQ byte-producing requesters using round-robin arbitration.
- Serializes the granted byte as a UART frame: start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits.
- Sits between on-chip byte sources and the `tx` pin driven onto the UART interface; the master monitor samples that line.
- Owns bit timing through a programmable baud divisor.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIV_W, 16, width of the baud divisor.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cfg_baud_div  input  DIV_W  clocks per bit; a value of 0 is treated as 1.
- cfg_parity_en  input  1  adds a parity bit after the data bits.
- cfg_parity_odd  input  1  1 = odd parity, 0 = even parity.
- cfg_two_stop  input  1  1 = two stop bits, 0 = one stop bit.
- req_valid  input  NUM_REQ  per-requester byte-valid.
- req_data  input  NUM_REQ*8  packed bytes; requester i occupies bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot acceptance pulse.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- grant_id  output  $clog2(NUM_REQ)  index of the requester being sent; holds its last value when idle.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, while reset==0):
  - tx=1, busy=0, req_ready=0, frame_done=0, grant_id=0.
  - Round-robin pointer=0, FSM=IDLE, baud and bit counters cleared.
  - Reset asserted mid-frame aborts the frame: tx goes high immediately and no frame_done is generated.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from the pointer upward, with wrap-around.
  - In that same cycle: req_ready[g]=1, latch req_data[g], latch all cfg_* inputs, grant_id=g, pointer=(g+1) mod NUM_REQ.
  - Next state is START.
  - If no request is valid: tx=1 and the pointer is unchanged.
- Handshake:
  - A byte transfers when req_valid[i] && req_ready[i].
  - req_ready is asserted only in the IDLE grant cycle, and only to one requester.
  - Requesters hold valid and data until they see ready. Dropping valid before ready is legal; that request is simply not granted.
- Bit timing:
  - A baud counter counts 0..max(cfg_baud_div,1)-1; each bit lasts exactly that many clocks.
  - On terminal count the FSM advances and the counter restarts at 0.
- Per-state output and transitions:
  - START: tx=0.
  - DATA: tx=shift[0], LSB first. An internal 3-bit counter runs 0..7; after bit 7 go to PARITY if parity is enabled, else STOP1.
  - PARITY: tx = XOR of the data byte for even parity, its inverse for odd parity.
  - STOP1: tx=1; go to STOP2 if two stop bits are configured, else finish.
  - STOP2: tx=1, then finish.
- Finish:
  - frame_done=1 for the cycle in which the last stop bit ends, then return to IDLE.
  - The earliest re-grant is the first IDLE cycle, so at least one idle clock at tx=1 separates frames.
- Latency: from the grant cycle, tx falls on the next clock edge.
- Frame length in clocks: div*(10 + parity_en + two_stop).
- busy=1 from START through the final stop bit, and 0 in IDLE.
- tx is a registered output with no glitches.
- cfg_* inputs changing mid-frame have no effect until the next grant.
- Fairness: a requester that holds valid continuously waits at most NUM_REQ-1 frames.

Decomposition:
- Package uart_sched_pkg holds:
  - enum state_e {IDLE, START, DATA, PARITY, STOP1, STOP2};
  - constant DATA_BITS=8;
  - function rr_pick(req, ptr), returning the granted index and a found flag.
- Sub-module uart_baud_counter (enable, divisor, tick output) generates the per-bit terminal count.
- Arbitration and the frame FSM stay in the top module.

Test Plan:
- Single frame: NUM_REQ=4, div=4, no parity, one stop bit; req_valid=0001, data=8'hA5.
  - req_ready=0001 for 1 cycle; tx shows 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks (40 clocks).
  - frame_done pulses once; grant_id=0.
- Round-robin: all four valid constantly, bytes 8'h10..8'h13.
  - Grant order 0,1,2,3,0; each byte appears on tx in that order.
  - Exactly one idle clock (tx=1) between consecutive frames.
- Parity and stop bits: div=2, data 8'h07, even parity, two stop bits → parity bit=1, frame is 24 clocks.
  - Same with odd parity → parity bit=0.
- Divisor edge and config freeze: cfg_baud_div=0 → each bit lasts 1 clock.
  - Changing cfg_baud_div from 4 to 8 mid-frame leaves the current frame at 4 clocks per bit; the next frame uses 8.
- Reset mid-frame: assert reset during DATA bit 3.
  - tx=1 and busy=0 immediately with no clock; no frame_done.
  - After release with requester 2 valid, requester 2 is granted (pointer starts at 0, searches upward).
- Valid withdrawn: requester 1 raises then drops valid while a frame for requester 0 is in progress.
  - Requester 1 is never granted; req_ready[1] stays 0.
